// File: rtl/jpeg_uart_tx.sv
// JPEG byte-stream output stage: valid/ready input into a small FIFO, drained as 8N1 UART frames.
// Optional even-parity bit (8E1 framing) is enabled by defining UART_PARITY_EN.
module jpeg_uart_tx #(
   parameter int CLK_FRE    = 50,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [7:0]                    in_data,
   input  logic                          in_last,
   output logic                          uart_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          frame_done
);

   localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CYCLE - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd4
   } state_t;
`endif

   // Handshake: a byte moves on a rising edge with in_valid && in_ready; in_ready
   // depends only on the registered level, and the source holds data while stalled.

   // FIFO storage and bookkeeping; entries are {last, data}
   logic [8:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic [8:0]    rd_entry;

   // Serialiser state
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          last_q, last_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          cnt_end;

   assign in_ready   = (level_q != LVL_FULL);
   assign push       = in_valid && in_ready;
   assign fifo_empty = (level_q == '0);
   assign rd_entry   = mem_q[rd_ptr_q];
   assign cnt_end    = (cnt_q == CNT_MAX);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_last, in_data};
      end
   end

   // State register: FIFO pointers and all serialiser registers
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         last_q   <= last_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic; the STOP exit pops directly into START so frames stay contiguous
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_end ? '0 : cnt_q + CW'(1);
      bit_d   = bit_q;
      data_d  = data_q;
      last_d  = last_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_end) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (cnt_end) begin
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (cnt_end) begin
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_end) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         data_d = rd_entry[7:0];
         last_d = rd_entry[8];
      end
   end

   // Output logic: line level and flags are registered from the next state
   always_comb begin
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_d];
`ifdef UART_PARITY_EN
         S_PARITY: tx_d = ^data_d;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE) || (level_d != '0);
      done_d = (state_q == S_STOP) && cnt_end && last_q;
   end

   assign uart_tx    = tx_q;
   assign busy       = busy_q;
   assign fifo_level = level_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_jpeg_uart_tx.sv
// Bench for jpeg_uart_tx: logs every cycle and compares against a frame-timeline model
// built from accepted bytes (start = max(accept+1, previous frame end)).
module tb_jpeg_uart_tx;

   localparam int CLK_FRE = 50;
   localparam int BAUD    = 5000000;
   localparam int DEPTH   = 16;
   localparam int CYCLE   = 10;
`ifdef UART_PARITY_EN
   localparam int NBITS = 11;
   localparam bit PAR   = 1'b1;
`else
   localparam int NBITS = 10;
   localparam bit PAR   = 1'b0;
`endif
   localparam int FRAME = NBITS * CYCLE;
   localparam int LOGN  = 65536;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic       uart_tx;
   logic       busy;
   logic [4:0] fifo_level;
   logic       frame_done;

   jpeg_uart_tx #(
      .CLK_FRE    (CLK_FRE),
      .BAUD_RATE  (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .sys_clk    (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .fifo_level (fifo_level),
      .frame_done (frame_done)
   );

   // Clock / cycle log: act_log[e] holds outputs after rising edge e
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [8:0] act_log [LOGN];
   always @(negedge clk) begin
      if (cyc < LOGN) act_log[cyc] <= {in_ready, uart_tx, frame_done, busy, fifo_level};
   end

   // Reference model: accepted bytes with accept edge and frame start edge
   int         m_acc[$];
   int         m_start[$];
   logic [7:0] exp_q[$];
   logic       m_last[$];
   int         prev_end = 0;

   int n_checks = 0;
   int n_fail   = 0;

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_model();
      m_acc.delete();
      m_start.delete();
      exp_q.delete();
      m_last.delete();
      prev_end = 0;
   endtask

   // Expected {ready, tx, done, busy, level} after edge e
   function automatic logic [8:0] exp_vec(input int e);
      int   lvl;
      int   k;
      logic tx, dn, bsy;
      lvl = 0; tx = 1'b1; dn = 1'b0; bsy = 1'b0;
      for (int i = 0; i < m_start.size(); i++) begin
         if (m_acc[i] <= e) lvl++;
         if (m_start[i] <= e) lvl--;
         if (e >= m_start[i] && e < m_start[i] + FRAME) begin
            bsy = 1'b1;
            k = (e - m_start[i]) / CYCLE;
            if (k == 0) tx = 1'b0;
            else if (k <= 8) tx = exp_q[i][k-1];
            else if (k == 9 && PAR) tx = ^exp_q[i];
            else tx = 1'b1;
         end
         if (m_last[i] && e == m_start[i] + FRAME) dn = 1'b1;
      end
      if (lvl > 0) bsy = 1'b1;
      return {lvl != DEPTH, tx, dn, bsy, lvl[4:0]};
   endfunction

   // Driver tasks
   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      clear_model();
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l);
      int waited;
      int acc;
      int st;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
         in_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      st  = (acc + 1 > prev_end) ? acc + 1 : prev_end;
      m_acc.push_back(acc);
      m_start.push_back(st);
      exp_q.push_back(d);
      m_last.push_back(l);
      prev_end = st + FRAME;
      @(posedge clk);
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_until(input int t);
      @(negedge clk);
      while (cyc <= t) @(negedge clk);
   endtask

   // Scenarios
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx: got %b required 1", uart_tx); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++;
      if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_fifo_level: got %0d required 0", fifo_level); end
      n_checks++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
      rst = 1'b0;
      clear_model();
   endtask

   task automatic test_single_byte();
      int          n, err, bad;
      logic [10:0] got, req;
      do_reset(2);
      push_byte(8'hA5, 1'b0);
      idle_in();
      n = m_acc[0];
      wait_until(n + 130);
`ifdef UART_PARITY_EN
      req = 11'b10101001010;
`else
      req = 11'b11101001010;
`endif
      n_checks++;
      if ({act_log[n][7], act_log[n+1][7]} !== 2'b10) begin
         n_fail++;
         $display("FAIL single_start_edge: tx at N,N+1 = %b%b required 10", act_log[n][7], act_log[n+1][7]);
      end
      for (int k = 0; k < 11; k++) got[k] = act_log[n + 1 + 10*k][7];
      n_checks++;
      if (got !== req) begin n_fail++; $display("FAIL single_bit_samples: got %b required %b", got, req); end
      n_checks++;
      if ({act_log[n+FRAME][5], act_log[n+FRAME+1][5], act_log[n+FRAME+1][7]} !== 3'b101) begin
         n_fail++;
         $display("FAIL single_end: busy@N+%0d,busy@N+%0d,tx = %b%b%b required 101", FRAME, FRAME+1,
                  act_log[n+FRAME][5], act_log[n+FRAME+1][5], act_log[n+FRAME+1][7]);
      end
      err = 0; bad = -1;
      for (int e = n; e <= n + 130; e++) if (act_log[e] !== exp_vec(e)) begin err++; if (bad < 0) bad = e; end
      n_checks++;
      if (err != 0) begin
         n_fail++;
         $display("FAIL single_window: edge %0d got {rdy,tx,done,busy,lvl}=%b required %b (%0d cycles)", bad, act_log[bad], exp_vec(bad), err);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b [4];
      int         s, err, bad, dn_cnt;
      logic [5:0] got;
      b[0] = 8'hFF; b[1] = 8'hD8; b[2] = 8'hFF; b[3] = 8'hE0;
      do_reset(2);
      for (int i = 0; i < 4; i++) push_byte(b[i], i == 3);
      idle_in();
      s = m_start[0];
      wait_until(s + 4*FRAME + 30);
      for (int i = 1; i < 4; i++) begin
         got[2*i-2] = act_log[s + i*FRAME - 1][7];
         got[2*i-1] = act_log[s + i*FRAME][7];
      end
      n_checks++;
      if (got !== 6'b010101) begin n_fail++; $display("FAIL burst_contiguous: stop/start pairs %b required 010101", got); end
      dn_cnt = 0;
      for (int e = s; e <= s + 4*FRAME + 30; e++) dn_cnt += int'(act_log[e][6]);
      n_checks++;
      if (dn_cnt !== 1 || act_log[s + 4*FRAME][6] !== 1'b1) begin
         n_fail++;
         $display("FAIL burst_frame_done: %0d pulses, at end-of-stop %b, required 1 pulse at edge S+%0d", dn_cnt, act_log[s+4*FRAME][6], 4*FRAME);
      end
      err = 0; bad = -1;
      for (int e = m_acc[0]; e <= s + 4*FRAME + 30; e++) if (act_log[e] !== exp_vec(e)) begin err++; if (bad < 0) bad = e; end
      n_checks++;
      if (err != 0) begin
         n_fail++;
         $display("FAIL burst_window: edge %0d got %b required %b (%0d cycles)", bad, act_log[bad], exp_vec(bad), err);
      end
   endtask

   task automatic test_full_fifo();
      int a, stop_e, err, bad, max_lvl;
      do_reset(2);
      for (int i = 0; i < 18; i++) push_byte(8'($urandom_range(0, 255)), i == 17);
      idle_in();
      a = m_acc[0];
      stop_e = prev_end + 20;
      wait_until(stop_e);
      max_lvl = 0;
      for (int e = a; e <= stop_e; e++) if (int'(act_log[e][4:0]) > max_lvl) max_lvl = int'(act_log[e][4:0]);
      n_checks++;
      if (max_lvl !== DEPTH) begin n_fail++; $display("FAIL full_max_level: got %0d required %0d", max_lvl, DEPTH); end
      err = 0; bad = -1;
      for (int e = a; e <= stop_e; e++) if (act_log[e] !== exp_vec(e)) begin err++; if (bad < 0) bad = e; end
      n_checks++;
      if (err != 0) begin
         n_fail++;
         $display("FAIL full_window: edge %0d got %b required %b (%0d cycles)", bad, act_log[bad], exp_vec(bad), err);
      end
   endtask

   task automatic test_reset_mid_frame();
      int s0, r, err, bad;
      do_reset(2);
      for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)), i == 4);
      idle_in();
      s0 = m_start[0];
      wait_until(s0 + 42);
      rst = 1'b1;
      r = cyc + 1;
      @(negedge clk);
      rst = 1'b0;
      wait_until(r + 300);
      err = 0; bad = -1;
      for (int e = m_acc[0]; e < r; e++) if (act_log[e] !== exp_vec(e)) begin err++; if (bad < 0) bad = e; end
      n_checks++;
      if (err != 0) begin
         n_fail++;
         $display("FAIL midrst_pre_window: edge %0d got %b required %b (%0d cycles)", bad, act_log[bad], exp_vec(bad), err);
      end
      n_checks++;
      if (act_log[r][7] !== 1'b1 || act_log[r][4:0] !== 5'd0) begin
         n_fail++;
         $display("FAIL midrst_after_edge: tx=%b level=%0d required tx=1 level=0", act_log[r][7], act_log[r][4:0]);
      end
      clear_model();
      err = 0; bad = -1;
      for (int e = r; e <= r + 300; e++) if (act_log[e] !== exp_vec(e)) begin err++; if (bad < 0) bad = e; end
      n_checks++;
      if (err != 0) begin
         n_fail++;
         $display("FAIL midrst_post_window: edge %0d got %b required %b (%0d cycles)", bad, act_log[bad], exp_vec(bad), err);
      end
   endtask

   task automatic test_random();
      int a, stop_e, err, bad, cnt, dn_cnt, tags;
      do_reset(2);
      for (int burst = 0; burst < 3; burst++) begin
         cnt = $urandom_range(1, 12);
         for (int j = 0; j < cnt; j++) begin
            push_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
               idle_in();
               repeat ($urandom_range(1, 60)) @(negedge clk);
            end
         end
         idle_in();
         repeat ($urandom_range(0, 400)) @(negedge clk);
      end
      a = m_acc[0];
      stop_e = prev_end + 20;
      wait_until(stop_e);
      tags = 0;
      foreach (m_last[i]) tags += int'(m_last[i]);
      dn_cnt = 0;
      for (int e = a; e <= stop_e; e++) dn_cnt += int'(act_log[e][6]);
      n_checks++;
      if (dn_cnt !== tags) begin n_fail++; $display("FAIL random_done_count: got %0d required %0d", dn_cnt, tags); end
      err = 0; bad = -1;
      for (int e = a; e <= stop_e; e++) if (act_log[e] !== exp_vec(e)) begin err++; if (bad < 0) bad = e; end
      n_checks++;
      if (err != 0) begin
         n_fail++;
         $display("FAIL random_window: edge %0d got %b required %b (%0d cycles)", bad, act_log[bad], exp_vec(bad), err);
      end
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity();
      int          n;
      logic [10:0] got;
      do_reset(2);
      push_byte(8'h07, 1'b0);
      idle_in();
      n = m_acc[0];
      wait_until(n + 130);
      for (int k = 0; k < 11; k++) got[k] = act_log[n + 1 + 10*k][7];
      n_checks++;
      if (got !== 11'b11000001110) begin n_fail++; $display("FAIL parity_frame: got %b required 11000001110", got); end
      n_checks++;
      if ({act_log[n+110][5], act_log[n+111][5]} !== 2'b10) begin
         n_fail++;
         $display("FAIL parity_length: busy@N+110,N+111 = %b%b required 10", act_log[n+110][5], act_log[n+111][5]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_full_fifo();
      test_reset_mid_frame();
      test_random();
`ifdef UART_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
